nonrestoring_divider: RTL and testbench

//  Sequential unsigned non-restoring divider: the inverse of the Booth

---
 rtl/nonrestoring_divider.sv | 99 +++++++++
 tb/tb_nonrestoring_divider.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/nonrestoring_divider.sv
// Sequential unsigned non-restoring divider: one quotient bit per clock,
// start/done handshake, divide-by-zero short-circuit straight to FIN.
module nonrestoring_divider #(
  parameter int WIDTH = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dataQ,
  input  logic [WIDTH-1:0] dataM,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] CORR = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   a;        // two's-complement partial remainder
  logic [WIDTH:0]   m;        // divisor, zero-extended
  logic [WIDTH-1:0] q;

  logic [WIDTH:0]   a_shift;
  logic [WIDTH:0]   a_step;
  logic [WIDTH:0]   a_fix;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    a_shift = {a[WIDTH-1:0], q[WIDTH-1]};
    a_step  = a[WIDTH] ? (a_shift + m) : (a_shift - m);
    a_fix   = a[WIDTH] ? (a + m) : a;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      a         <= '0;
      m         <= '0;
      q         <= '0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m     <= {1'b0, dataM};
            q     <= dataQ;
            a     <= '0;
            count <= CW'(WIDTH);
            busy  <= 1'b1;
            dbz   <= 1'b0;
            if (dataM == '0) begin
              quotient  <= '1;
              remainder <= dataQ;
              dbz       <= 1'b1;
              done      <= 1'b1;
              state     <= FIN;
            end else begin
              state <= ITER;
            end
          end
        end
        ITER: begin
          a     <= a_step;
          q     <= {q[WIDTH-2:0], ~a_step[WIDTH]};
          count <= count - CW'(1);
          if (count == CW'(1)) state <= CORR;
        end
        CORR: begin
          // A negative final remainder is restored by one extra add.
          quotient  <= q;
          remainder <= a_fix[WIDTH-1:0];
          done      <= 1'b1;
          state     <= FIN;
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Self-checking bench for nonrestoring_divider: directed vector table,
// handshake corner sequences and a random sweep against an arithmetic model.
module tb_nonrestoring_divider;

  localparam int W = 15;
  localparam int NORMAL_LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dataQ, dataM;
  logic [W-1:0] quotient, remainder;
  logic         busy, done, dbz;

  int vectors = 0;
  int miscompares = 0;

  nonrestoring_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dataQ(dataQ), .dataM(dataM),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done), .dbz(dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q_in;
    logic [W-1:0] m_in;
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    logic         exp_dbz;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs one operation from accept to the cycle after done and checks
  // results, latency and handshake. Optionally re-pulses start mid-ITER.
  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                       input bit interfere);
    int n;
    @(negedge clk);
    dataQ = a; dataM = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dataQ = W'($urandom_range(0, (1 << W) - 1));
    dataM = W'($urandom_range(0, (1 << W) - 1));
    check({name, ".busy"}, 32'(busy), 32'd1);
    n = 1;
    while (!done && n < 60) begin
      if (interfere && n == 3) begin
        start = 1'b1; dataQ = ~a; dataM = b + W'(1);
      end
      if (interfere && n == 5) start = 1'b0;
      @(negedge clk);
      n++;
    end
    check({name, ".latency"}, 32'(n), (b == '0) ? 32'd1 : 32'(NORMAL_LAT));
    check({name, ".quotient"}, 32'(quotient), 32'(eq));
    check({name, ".remainder"}, 32'(remainder), 32'(er));
    check({name, ".dbz"}, 32'(dbz), 32'(edbz));
    check({name, ".busy_fin"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({name, ".done_len"}, 32'(done), 32'd0);
    check({name, ".busy_idle"}, 32'(busy), 32'd0);
  endtask

  vec_t tbl[10];

  initial begin
    int n;
    int pulses;
    logic [W-1:0] ra, rb, eq, er;

    tbl[0] = '{15'd5,     15'd4,     15'd1,     15'd1,  1'b0};
    tbl[1] = '{15'd100,   15'd7,     15'd14,    15'd2,  1'b0};
    tbl[2] = '{15'd32767, 15'd1,     15'd32767, 15'd0,  1'b0};
    tbl[3] = '{15'd10,    15'd20,    15'd0,     15'd10, 1'b0};
    tbl[4] = '{15'd32767, 15'd32767, 15'd1,     15'd0,  1'b0};
    tbl[5] = '{15'd3,     15'd0,     15'h7FFF,  15'd3,  1'b1};
    tbl[6] = '{15'd9,     15'd3,     15'd3,     15'd0,  1'b0};
    tbl[7] = '{15'd0,     15'd5,     15'd0,     15'd0,  1'b0};
    tbl[8] = '{15'd1,     15'd32767, 15'd0,     15'd1,  1'b0};
    tbl[9] = '{15'd32766, 15'd2,     15'd16383, 15'd0,  1'b0};

    rst = 1'b0; start = 1'b0; dataQ = '0; dataM = '0;
    #12;
    check("reset.quotient", 32'(quotient), 32'd0);
    check("reset.remainder", 32'(remainder), 32'd0);
    check("reset.flags", {29'd0, busy, done, dbz}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i])
      do_op($sformatf("vec%0d", i), tbl[i].q_in, tbl[i].m_in,
            tbl[i].exp_q, tbl[i].exp_r, tbl[i].exp_dbz, 1'b0);

    // start re-pulsed mid-ITER with other data is ignored
    do_op("interfere", 15'd200, 15'd9, 15'd22, 15'd2, 1'b0, 1'b1);

    // start held high: ignored in FIN, next op accepted after one IDLE cycle
    @(negedge clk);
    dataQ = 15'd1000; dataM = 15'd30; start = 1'b1;
    @(negedge clk);
    dataQ = 15'd77; dataM = 15'd8;
    n = 1;
    while (!done && n < 60) begin @(negedge clk); n++; end
    check("held.lat1", 32'(n), 32'(NORMAL_LAT));
    check("held.q1", 32'(quotient), 32'd33);
    check("held.r1", 32'(remainder), 32'd10);
    @(negedge clk);
    n = 1;
    while (!done && n < 60) begin @(negedge clk); n++; end
    check("held.lat2", 32'(n), 32'(NORMAL_LAT + 1));
    check("held.q2", 32'(quotient), 32'd9);
    check("held.r2", 32'(remainder), 32'd5);
    start = 1'b0;
    @(negedge clk);
    check("held.done_len", 32'(done), 32'd0);
    @(negedge clk);

    // async reset mid-ITER aborts with no clock edge needed
    dataQ = 15'd12345; dataM = 15'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst.quotient", 32'(quotient), 32'd0);
    check("midrst.remainder", 32'(remainder), 32'd0);
    check("midrst.flags", {29'd0, busy, done, dbz}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    repeat (20) begin @(negedge clk); if (done) pulses++; end
    check("midrst.no_done", 32'(pulses), 32'd0);
    do_op("after_rst", 15'd6, 15'd4, 15'd1, 15'd2, 1'b0, 1'b0);

    // random sweep against the arithmetic model
    for (int k = 0; k < 2000; k++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        default: rb = W'($urandom_range(1, (1 << W) - 1));
      endcase
      if (rb == '0) begin
        eq = '1; er = ra;
      end else begin
        eq = ra / rb; er = ra % rb;
      end
      do_op($sformatf("rnd%0d", k), ra, rb, eq, er, (rb == '0), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
